// File: rtl/sram_like_if.sv
// Request/response signal bundle for the SRAM-like bus: one request channel
// (req/addr_ok handshake) and a fixed-latency response pulse (data_ok).
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, rdata, data_ok
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, rdata, data_ok
  );
endinterface

// File: rtl/sram_like_slave.sv
// SRAM-like slave: word memory with byte-lane writes, read data captured at accept
// and returned through a fixed LAT-deep pipeline, in order, one data_ok per accept.
module sram_like_slave #(
  parameter int unsigned MEM_AW     = 12,
  parameter int unsigned LAT        = 2,
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned RAND_STALL = 0
) (
  input logic         clk,
  input logic         reset,
  sram_like_if.slave  bus
);

  localparam int unsigned Depth  = 2 ** MEM_AW;
  localparam logic [2:0]  MaxOut = 3'(MAX_OUT);

  logic [7:0]        lfsr_q, lfsr_d;
  logic              stall_ok;
  logic              accept;
  logic              retire_now;
  logic [2:0]        out_q, out_d;
  logic [MEM_AW-1:0] widx;
  logic [31:0]       mem_q [Depth];
  logic [LAT-1:0]    vld_q;
  logic [31:0]       dat_q [LAT];
  logic              unused_bits;

  assign widx        = bus.addr[MEM_AW+1:2];
  // Size and out-of-range address bits carry no meaning for this memory.
  assign unused_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign stall_ok = (RAND_STALL != 0) ? lfsr_q[0] : 1'b1;

  assign retire_now  = vld_q[LAT-1];
  // A retiring response frees its slot in the same cycle, so the limit never bubbles.
  assign bus.addr_ok = ~reset & ((out_q < MaxOut) | retire_now) & stall_ok;
  assign accept      = bus.req & bus.addr_ok;

  assign bus.data_ok = vld_q[LAT-1];
  assign bus.rdata   = dat_q[LAT-1];

  always_comb begin
    out_d = out_q;
    unique case ({accept, retire_now})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'h5A;
      out_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      out_q  <= out_d;
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem_q[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // Write responses and empty slots carry zero data so rdata is 0 whenever data_ok is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LAT); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= accept;
      dat_q[0] <= (accept && !bus.wr) ? mem_q[widx] : 32'h0;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Scoreboard bench for sram_like_slave: three configurations (default, LAT3/MAX_OUT1,
// random stall), directed vectors with hand-derived responses checked by a monitor.
module tb_sram_like_slave;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] lf_m;
  bit   rs_on = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  sram_like_if if0 ();
  sram_like_if if1 ();
  sram_like_if if2 ();

  sram_like_slave #(.MEM_AW(12), .LAT(2), .MAX_OUT(2), .RAND_STALL(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  sram_like_slave #(.MEM_AW(12), .LAT(3), .MAX_OUT(1), .RAND_STALL(0)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  sram_like_slave #(.MEM_AW(12), .LAT(2), .MAX_OUT(2), .RAND_STALL(1)) u_dut2 (
    .clk(clk), .reset(reset), .bus(if2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR, x^8+x^6+x^5+x^4+1, seeded 8'h5A.
  always @(posedge clk) begin
    if (reset) lf_m <= 8'h5A;
    else       lf_m <= {lf_m[6:0], lf_m[7] ^ lf_m[5] ^ lf_m[4] ^ lf_m[3]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input int inst);
    return (inst == 1) ? 3 : 2;
  endfunction

  function automatic logic ok_of(input int inst);
    case (inst)
      0:       return if0.req & if0.addr_ok;
      1:       return if1.req & if1.addr_ok;
      default: return if2.req & if2.addr_ok;
    endcase
  endfunction

  task automatic drive(input int inst, input logic r, input logic w, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    case (inst)
      0: begin
        if0.req = r; if0.wr = w; if0.size = 2'd2; if0.wstrb = st; if0.addr = a; if0.wdata = d;
      end
      1: begin
        if1.req = r; if1.wr = w; if1.size = 2'd2; if1.wstrb = st; if1.addr = a; if1.wdata = d;
      end
      default: begin
        if2.req = r; if2.wr = w; if2.size = 2'd2; if2.wstrb = st; if2.addr = a; if2.wdata = d;
      end
    endcase
  endtask

  task automatic idle(input int inst);
    drive(inst, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic push(input int inst, input exp_t e);
    case (inst)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called right after a rising edge; returns right after the accepting edge with req still high.
  task automatic issue(input int inst, input logic w, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                       output int acc);
    int   waits = 0;
    bit   done  = 0;
    exp_t e;
    acc = -1;
    drive(inst, 1'b1, w, st, a, d);
    while (!done) begin
      @(negedge clk);
      if (ok_of(inst)) begin
        done   = 1;
        acc    = cyc;
        e.due  = cyc + lat_of(inst);
        e.data = w ? 32'h0 : exp_rd;
        push(inst, e);
      end else if (++waits > 40) begin
        done = 1;
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout inst=%0d addr=%h actual=no_accept required=accept", inst, a);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon(input int inst, input logic dok, input logic [31:0] rd);
    exp_t e;
    int   n;
    case (inst)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    if (dok) begin
      if (n == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_data_ok inst=%0d cyc=%0d actual=1 required=0", inst, cyc);
      end else begin
        case (inst)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("resp_cycle_u%0d", inst), cyc, e.due);
        chk($sformatf("resp_rdata_u%0d", inst), rd, e.data);
      end
    end else begin
      chk($sformatf("idle_rdata_u%0d", inst), rd, 32'h0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.data_ok, if0.rdata);
    mon(1, if1.data_ok, if1.rdata);
    mon(2, if2.data_ok, if2.rdata);
    if (rs_on) chk("rand_addr_ok", {31'h0, if2.addr_ok}, {31'h0, lf_m[0]});
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, prev, start, k;
    reset = 1'b1;
    idle(0); idle(1); idle(2);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    chk("rst_addr_ok_u0", {31'h0, if0.addr_ok}, 32'h0);
    chk("rst_addr_ok_u2", {31'h0, if2.addr_ok}, 32'h0);
    chk("rst_data_ok_u0", {31'h0, if0.data_ok}, 32'h0);
    chk("rst_rdata_u1", if1.rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(0);
    @(posedge clk);
    #1;

    // Single-beat read after full write
    issue(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, c);
    idle(0);
    repeat (3) @(posedge clk);
    #1;
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, c);
    idle(0);
    repeat (4) @(posedge clk);
    #1;

    // Partial write: lanes 0 and 2 replaced
    issue(0, 1'b1, 4'hF, 32'h104, 32'h11223344, 32'h0, c);
    issue(0, 1'b1, 4'b0101, 32'h104, 32'hAABBCCDD, 32'h0, c);
    issue(0, 1'b0, 4'h0, 32'h106, 32'h0, 32'h11BB33DD, c);
    idle(0);
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back at MAX_OUT = LAT = 2: one accept every cycle
    prev = -1;
    for (int i = 0; i < 12; i++) begin
      k = i % 6;
      if (i < 6) issue(0, 1'b1, 4'hF, 32'h200 + 32'(4 * k), 32'hA5A50000 + 32'(k), 32'h0, c);
      else       issue(0, 1'b0, 4'h0, 32'h200 + 32'(4 * k), 32'h0, 32'hA5A50000 + 32'(k), c);
      if (i > 0) chk("b2b_spacing", 32'(c - prev), 32'd1);
      prev = c;
    end
    idle(0);
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-flight: the accepted read is discarded and nothing returns
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, c);
    drive(0, 1'b1, 1'b0, 4'h0, 32'h104, 32'h0);
    reset = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("midrst_addr_ok", {31'h0, if0.addr_ok}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(0);
    @(negedge clk);
    chk("midrst_outstanding", {29'h0, u_dut0.out_q}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, c);
    idle(0);
    repeat (4) @(posedge clk);
    #1;

    // MAX_OUT = 1, LAT = 3: accepts only in the retiring cycle, every 3 cycles
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      k = i % 2;
      if (i < 2) issue(1, 1'b1, 4'hF, 32'h300 + 32'(4 * k), 32'hC3C30000 + 32'(k), 32'h0, c);
      else       issue(1, 1'b0, 4'h0, 32'h300 + 32'(4 * k), 32'h0, 32'hC3C30000 + 32'(k), c);
      if (i > 0) chk("limit_spacing", 32'(c - prev), 32'd3);
      prev = c;
    end
    idle(1);
    repeat (5) @(posedge clk);
    #1;

    // Random stall: addr_ok follows lfsr[0] while req stays high for 64 cycles
    start = cyc;
    drive(2, 1'b1, 1'b1, 4'hF, 32'h400, 32'h5A000000);
    rs_on = 1;
    for (int i = 0; cyc - start < 64; i++) begin
      k = i % 8;
      if (i < 8) issue(2, 1'b1, 4'hF, 32'h400 + 32'(4 * k), 32'h5A000000 + 32'(k), 32'h0, c);
      else       issue(2, 1'b0, 4'h0, 32'h400 + 32'(4 * k), 32'h0, 32'h5A000000 + 32'(k), c);
    end
    rs_on = 0;
    idle(2);

    repeat (8) @(posedge clk);
    #1;
    chk("drain_u0", 32'(q0.size()), 32'h0);
    chk("drain_u1", 32'(q1.size()), 32'h0);
    chk("drain_u2", 32'(q2.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
